// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - raster phase type, default 640x480@60 timing, phase boundary helper
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } phase_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Counters are 10 bits wide, so no axis may exceed this many counts.
  localparam int MAX_TOTAL = 1024;

  // Last count value that still belongs to a phase on an axis laid out
  // VISIBLE, FRONT, SYNC, BACK starting at zero.
  function automatic logic [9:0] phase_end(input phase_t phase, input int vis, input int fp,
                                           input int sp, input int bp);
    int last;
    case (phase)
      PH_VISIBLE: last = vis - 1;
      PH_FRONT:   last = vis + fp - 1;
      PH_SYNC:    last = vis + fp + sp - 1;
      default:    last = vis + fp + sp + bp - 1;
    endcase
    return 10'(last);
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// rtl/vga_axis_timer.sv - one raster axis: position counter plus registered phase FSM
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       advance_i,
  output logic [9:0] count_o,
  output phase_t     phase_o,
  output logic       wrap_o,
  output logic       sync_o
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [9:0] LAST = 10'(TOTAL - 1);

  // Zero-length phases would let the FSM skip past its boundary, and totals
  // beyond the counter range would never wrap correctly.
  if (TOTAL > MAX_TOTAL || VISIBLE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_timing
    $error("vga_axis_timer: every phase must be >= 1 and the axis total <= 1024");
  end

  logic [9:0] count_q, count_d;
  phase_t     phase_q, phase_d;

  assign wrap_o = advance_i && (count_q == LAST);

  // Next position and phase; phase steps on the last count of the current phase.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (advance_i) begin
      count_d = (count_q == LAST) ? 10'd0 : count_q + 10'd1;
      if (count_q == phase_end(phase_q, VISIBLE, FRONT, SYNC, BACK)) begin
        case (phase_q)
          PH_VISIBLE: phase_d = PH_FRONT;
          PH_FRONT:   phase_d = PH_SYNC;
          PH_SYNC:    phase_d = PH_BACK;
          default:    phase_d = PH_VISIBLE;
        endcase
      end
    end
  end

  // Counter and phase registered together so phase decode never lags the count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      phase_q <= PH_VISIBLE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count_o = count_q;
  assign phase_o = phase_q;
  assign sync_o  = (phase_q == PH_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster generator: position, blank, syncs, frame strobes and counter
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  // active_q is low in the reset cycles and goes high on the first release
  // edge; holding the counters until then makes the first running cycle
  // present (0,0) again, this time as a visible pixel with frame_start.
  logic        active_q, active_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [9:0]  h_count, v_count;
  phase_t      h_phase, v_phase;
  logic        h_wrap, v_wrap, h_sync, v_sync;

  vga_axis_timer #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_timer (
    .clk_i    (vga_clk),
    .reset_i  (reset),
    .advance_i(active_q),
    .count_o  (h_count),
    .phase_o  (h_phase),
    .wrap_o   (h_wrap),
    .sync_o   (h_sync)
  );

  vga_axis_timer #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_timer (
    .clk_i    (vga_clk),
    .reset_i  (reset),
    .advance_i(h_wrap),
    .count_o  (v_count),
    .phase_o  (v_phase),
    .wrap_o   (v_wrap),
    .sync_o   (v_sync)
  );

  // v_wrap only fires on a horizontal wrap, so it marks the joint frame wrap.
  always_comb begin
    active_d      = ~reset;
    frame_count_d = frame_count_q;
    if (v_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // Run flag and completed-frame counter.
  always_ff @(posedge vga_clk) begin
    active_q <= active_d;
    if (reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX        = h_count;
  assign DrawY        = v_count;
  assign blank        = active_q && (h_phase == PH_VISIBLE) && (v_phase == PH_VISIBLE);
  assign hs           = h_sync ^ SYNC_ACTIVE_LOW;
  assign vs           = v_sync ^ SYNC_ACTIVE_LOW;
  assign frame_start  = active_q && (h_count == 10'd0) && (v_count == 10'd0);
  assign vblank_start = active_q && (h_count == 10'd0) && (v_count == 10'(V_VISIBLE));
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  // Default 640x480 instance: reset, line-level and mid-line reset checks.
  localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VV = 480;
  localparam int D_HT = D_HV + D_HF + D_HS + D_HB;

  // Reduced raster instance (active-high syncs) for frame-level checks.
  localparam int S_HV = 20, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VV = 12, S_VF = 2, S_VS = 3, S_VB = 4;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FT = S_HT * S_VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst = 1'b1, s_rst = 1'b1;
  logic [9:0]  d_x, d_y, s_x, s_y;
  logic        d_blank, d_hs, d_vs, d_fs, d_vbs;
  logic        s_blank, s_hs, s_vs, s_fs, s_vbs;
  logic [15:0] d_fc, s_fc;

  int n_tests = 0;
  int n_fail  = 0;

  bit          d_track = 1'b0;
  bit          s_track = 1'b0;
  int          s_t = 0;
  int          s_fc_base = 0;
  logic [15:0] force_val;
  logic [40:0] mon_exp, mon_got;

  vga_timing_gen dut_d (
    .vga_clk(clk), .reset(d_rst), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
    .hs(d_hs), .vs(d_vs), .frame_start(d_fs), .vblank_start(d_vbs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_ACTIVE_LOW(1'b0)
  ) dut_s (
    .vga_clk(clk), .reset(s_rst), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .vblank_start(s_vbs), .frame_count(s_fc)
  );

  // Expected outputs t cycles after reset release, from raster arithmetic.
  function automatic logic [40:0] s_model(input int t, input int fc_base);
    int   x, y, f;
    logic bl, hs_a, vs_a, fs, vb;
    x    = t % S_HT;
    y    = (t / S_HT) % S_VT;
    f    = t / S_FT;
    bl   = (x < S_HV) && (y < S_VV);
    hs_a = (x >= S_HV + S_HF) && (x < S_HV + S_HF + S_HS);
    vs_a = (y >= S_VV + S_VF) && (y < S_VV + S_VF + S_VS);
    fs   = (x == 0) && (y == 0);
    vb   = (x == 0) && (y == S_VV);
    return {10'(x), 10'(y), bl, hs_a, vs_a, fs, vb, 16'(fc_base + f)};
  endfunction

  // Per-cycle model comparison (reduced) and invariants (default).
  always @(negedge clk) begin
    if (s_track) begin
      mon_exp = s_model(s_t, s_fc_base);
      mon_got = {s_x, s_y, s_blank, s_hs, s_vs, s_fs, s_vbs, s_fc};
      n_tests++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL s_model t=%0d got=%h required=%h", s_t, mon_got, mon_exp);
      end
      s_t++;
    end
    if (d_track) begin
      n_tests++;
      if (d_blank !== ((int'(d_x) < D_HV) && (int'(d_y) < D_VV))) begin
        n_fail++;
        $display("FAIL inv_blank x=%0d y=%0d blank=%b required=%b", d_x, d_y, d_blank,
                 ((int'(d_x) < D_HV) && (int'(d_y) < D_VV)));
      end
      n_tests++;
      if (d_blank === 1'b1 && (d_hs !== 1'b1 || d_vs !== 1'b1)) begin
        n_fail++;
        $display("FAIL inv_sync_in_visible x=%0d y=%0d hs=%b vs=%b required hs=1 vs=1", d_x, d_y, d_hs, d_vs);
      end
      n_tests++;
      if (d_fs === 1'b1 && d_vbs === 1'b1) begin
        n_fail++;
        $display("FAIL inv_strobes x=%0d y=%0d frame_start=%b vblank_start=%b required not both", d_x, d_y, d_fs, d_vbs);
      end
    end
  end

  task automatic test_reset();
    d_track = 1'b0;
    s_track = 1'b0;
    @(posedge clk); #1;
    d_rst = 1'b1;
    s_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({d_x, d_y, d_blank, d_hs, d_vs, d_fs, d_vbs, d_fc} !== {10'd0, 10'd0, 5'b01100, 16'd0}) begin
        n_fail++;
        $display("FAIL reset_hold_d cyc=%0d x=%0d y=%0d bl=%b hs=%b vs=%b fs=%b vb=%b fc=%0d required 0,0,0,1,1,0,0,0",
                 i, d_x, d_y, d_blank, d_hs, d_vs, d_fs, d_vbs, d_fc);
      end
      n_tests++;
      if ({s_x, s_y, s_blank, s_hs, s_vs, s_fs, s_vbs, s_fc} !== {10'd0, 10'd0, 5'b00000, 16'd0}) begin
        n_fail++;
        $display("FAIL reset_hold_s cyc=%0d x=%0d y=%0d bl=%b hs=%b vs=%b fs=%b vb=%b fc=%0d required all 0",
                 i, s_x, s_y, s_blank, s_hs, s_vs, s_fs, s_vbs, s_fc);
      end
    end
    d_rst = 1'b0;
    s_rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({d_x, d_y, d_blank, d_fs, d_vbs, d_fc} !== {10'd0, 10'd0, 3'b110, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_release x=%0d y=%0d bl=%b fs=%b vb=%b fc=%0d required 0,0,1,1,0,0",
               d_x, d_y, d_blank, d_fs, d_vbs, d_fc);
    end
    s_t       = 0;
    s_fc_base = 0;
    s_track   = 1'b1;
    d_track   = 1'b1;
  endtask

  task automatic test_line();
    int hs_low = 0, first_hs = -1, last_hs = -1, bad_hs = 0;
    int fall_from = -1, fall_to = -1;
    int wr_x = -1, wr_py = -1, wr_y = -1;
    int x, px, py;
    logic pb;
    px = int'(d_x);
    py = int'(d_y);
    pb = d_blank;
    for (int c = 1; c <= D_HT; c++) begin
      @(posedge clk); #1;
      x = int'(d_x);
      if (d_hs === 1'b0) begin
        hs_low++;
        if (first_hs < 0) first_hs = x;
        last_hs = x;
      end
      if ((d_hs === 1'b0) != ((x >= D_HV + D_HF) && (x < D_HV + D_HF + D_HS))) bad_hs++;
      if (pb === 1'b1 && d_blank === 1'b0 && fall_from < 0) begin
        fall_from = px;
        fall_to   = x;
      end
      if (px == D_HT - 1) begin
        wr_x  = x;
        wr_py = py;
        wr_y  = int'(d_y);
      end
      px = x;
      py = int'(d_y);
      pb = d_blank;
    end
    n_tests++;
    if (hs_low != D_HS) begin
      n_fail++;
      $display("FAIL line_hs_width got=%0d required=%0d", hs_low, D_HS);
    end
    n_tests++;
    if (first_hs != D_HV + D_HF || last_hs != D_HV + D_HF + D_HS - 1) begin
      n_fail++;
      $display("FAIL line_hs_span got=%0d..%0d required=%0d..%0d", first_hs, last_hs,
               D_HV + D_HF, D_HV + D_HF + D_HS - 1);
    end
    n_tests++;
    if (bad_hs != 0) begin
      n_fail++;
      $display("FAIL line_hs_position misplaced=%0d required=0", bad_hs);
    end
    n_tests++;
    if (fall_from != D_HV - 1 || fall_to != D_HV) begin
      n_fail++;
      $display("FAIL line_blank_fall got=%0d->%0d required=%0d->%0d", fall_from, fall_to, D_HV - 1, D_HV);
    end
    n_tests++;
    if (wr_x != 0 || wr_py != 0 || wr_y != 1) begin
      n_fail++;
      $display("FAIL line_wrap x=%0d y=%0d->%0d required x=0 y=0->1", wr_x, wr_py, wr_y);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (int'(d_x) != 700 && guard < 4 * D_HT) begin
      @(posedge clk); #1;
      guard++;
    end
    n_tests++;
    if (int'(d_x) != 700 || d_hs !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_reach x=%0d hs=%b required x=700 hs=0", d_x, d_hs);
    end
    d_track = 1'b0;
    d_rst   = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({d_x, d_y, d_hs, d_blank, d_fs, d_fc} !== {10'd0, 10'd0, 3'b100, 16'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_hold x=%0d y=%0d hs=%b bl=%b fs=%b fc=%0d required 0,0,1,0,0,0",
               d_x, d_y, d_hs, d_blank, d_fs, d_fc);
    end
    d_rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({d_x, d_y, d_blank, d_fs} !== {10'd0, 10'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL mid_reset_release x=%0d y=%0d bl=%b fs=%b required 0,0,1,1", d_x, d_y, d_blank, d_fs);
    end
    d_track = 1'b1;
  endtask

  task automatic test_frame();
    int vbs_n = 0, vbs_x = -1, vbs_y = -1, vs_act = 0, next_fs = -1, fc_at = -1;
    @(posedge clk); #1;
    s_track = 1'b0;
    s_rst   = 1'b1;
    @(posedge clk); #1;
    s_rst = 1'b0;
    @(posedge clk); #1;
    s_t       = 0;
    s_fc_base = 0;
    s_track   = 1'b1;
    n_tests++;
    if (s_fs !== 1'b1 || s_blank !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_first fs=%b bl=%b required 1,1", s_fs, s_blank);
    end
    for (int c = 1; c <= S_FT; c++) begin
      @(posedge clk); #1;
      if (s_vbs === 1'b1) begin
        vbs_n++;
        vbs_x = int'(s_x);
        vbs_y = int'(s_y);
      end
      if (s_vs === 1'b1) vs_act++;
      if (s_fs === 1'b1 && next_fs < 0) begin
        next_fs = c;
        fc_at   = int'(s_fc);
      end
    end
    n_tests++;
    if (vbs_n != 1 || vbs_x != 0 || vbs_y != S_VV) begin
      n_fail++;
      $display("FAIL frame_vblank pulses=%0d at (%0d,%0d) required 1 at (0,%0d)", vbs_n, vbs_x, vbs_y, S_VV);
    end
    n_tests++;
    if (vs_act != S_VS * S_HT) begin
      n_fail++;
      $display("FAIL frame_vs_width got=%0d required=%0d", vs_act, S_VS * S_HT);
    end
    n_tests++;
    if (next_fs != S_FT || fc_at != 1) begin
      n_fail++;
      $display("FAIL frame_period next_fs=%0d fc=%0d required %0d,1", next_fs, fc_at, S_FT);
    end
  endtask

  task automatic test_random_reset();
    for (int k = 0; k < 4; k++) begin
      int wait_n;
      int hold;
      wait_n = $urandom_range(2 * S_FT, 1);
      hold   = $urandom_range(4, 1);
      repeat (wait_n) @(posedge clk);
      #1;
      s_track = 1'b0;
      s_rst   = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        n_tests++;
        if ({s_x, s_y, s_blank, s_hs, s_vs, s_fs, s_vbs, s_fc} !== {10'd0, 10'd0, 5'b00000, 16'd0}) begin
          n_fail++;
          $display("FAIL rand_reset_hold k=%0d x=%0d y=%0d bl=%b hs=%b vs=%b fc=%0d required all 0",
                   k, s_x, s_y, s_blank, s_hs, s_vs, s_fc);
        end
      end
      s_rst = 1'b0;
      @(posedge clk); #1;
      s_t       = 0;
      s_fc_base = 0;
      s_track   = 1'b1;
      n_tests++;
      if ({s_x, s_y, s_blank, s_fs, s_fc} !== {10'd0, 10'd0, 2'b11, 16'd0}) begin
        n_fail++;
        $display("FAIL rand_reset_release k=%0d x=%0d y=%0d bl=%b fs=%b fc=%0d required 0,0,1,1,0",
                 k, s_x, s_y, s_blank, s_fs, s_fc);
      end
    end
  endtask

  task automatic test_fc_wrap();
    for (int k = 0; k < 2; k++) begin
      int guard;
      repeat ($urandom_range(S_FT, 1)) @(posedge clk);
      #1;
      if (int'(s_x) == S_HT - 1 && int'(s_y) == S_VT - 1) begin
        @(posedge clk); #1;
      end
      force_val = (k == 0) ? 16'hFFFF : 16'($urandom);
      force dut_s.frame_count_q = force_val;
      s_fc_base = int'(force_val) - s_t / S_FT;
      @(posedge clk); #1;
      release dut_s.frame_count_q;
      guard = 0;
      do begin
        @(posedge clk); #1;
        guard++;
      end while (!(s_x == 10'd0 && s_y == 10'd0) && guard < 2 * S_FT);
      n_tests++;
      if (s_fc !== force_val + 16'd1 || s_fs !== 1'b1) begin
        n_fail++;
        $display("FAIL fc_wrap k=%0d fc=%h fs=%b required fc=%h fs=1", k, s_fc, s_fs, force_val + 16'd1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_mid_reset();
    test_frame();
    test_random_reset();
    test_fc_wrap();
    @(posedge clk); #1;
    s_track = 1'b0;
    d_track = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
